// File: rtl/ahb_slave_interface_if.sv
// AHB-Lite slave front-end bus bundle: master-side stimulus, controller return path and slave outputs.
interface ahb_slave_interface_if #(
  parameter int unsigned P_NSEL = 3
);
  // AHB request side
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [31:0]       Haddr;
  logic [31:0]       Hwdata;
  // APB controller return path
  logic [31:0]       Prdata;
  logic              Pready_ctl;
  // AHB response side
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [31:0]       Hrdata;
  // Bridge-facing pipeline and decode
  logic              valid;
  logic [31:0]       Haddr1;
  logic [31:0]       Haddr2;
  logic [31:0]       Hwdata1;
  logic [31:0]       Hwdata2;
  logic              Hwritereg;
  logic              Hwritereg1;
  logic [P_NSEL-1:0] tempselx;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready_ctl,
    output Hreadyout, Hresp, Hrdata, valid, Haddr1, Haddr2, Hwdata1, Hwdata2,
           Hwritereg, Hwritereg1, tempselx
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready_ctl,
    input  Hreadyout, Hresp, Hrdata, valid, Haddr1, Haddr2, Hwdata1, Hwdata2,
           Hwritereg, Hwritereg1, tempselx
  );
endinterface

// File: rtl/ahb_slave_interface.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: phase pipeline, peripheral decode,
// transfer qualification and the two-cycle OKAY/ERROR response machine.
module ahb_slave_interface #(
  parameter logic [31:0] P_BASE      = 32'h8000_0000,
  parameter int unsigned P_SLOT_LOG2 = 26,
  parameter int unsigned P_NSEL      = 3
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  ahb_slave_interface_if.slave  bus
);

  // Size of the whole mapped region; 33 bits so base + span can reach 2^32.
  localparam logic [32:0] LP_SPAN = 33'(P_NSEL) << P_SLOT_LOG2;

  localparam logic [1:0] LP_RESP_OKAY  = 2'b00;
  localparam logic [1:0] LP_RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OKAY = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [31:0]       offset;
  logic [31:0]       slot;
  logic              in_map;
  logic              xfer_req;
  logic              valid_c;
  logic [P_NSEL-1:0] sel_c;

  // Address window decode relative to the peripheral base.
  always_comb begin
    offset   = bus.Haddr - P_BASE;
    slot     = offset >> P_SLOT_LOG2;
    in_map   = (bus.Haddr >= P_BASE) && ({1'b0, offset} < LP_SPAN);
    xfer_req = bus.Hreadyin & bus.Htrans[1];
  end

  // One-hot peripheral select; all zero outside the mapped region.
  always_comb begin
    sel_c = '0;
    for (int k = 0; k < int'(P_NSEL); k++) begin
      sel_c[k] = in_map && (slot == 32'(k));
    end
  end

  // Qualified transfer: the address phase is ignored while the master is held in ERR1.
  always_comb begin
    valid_c = xfer_req & in_map & (state != ST_ERR1);
  end

  assign bus.tempselx = sel_c;
  assign bus.valid    = valid_c;
  assign bus.Hrdata   = bus.Prdata;

  // Address, data and direction pipeline, advanced only when the bus is ready.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      bus.Haddr1     <= '0;
      bus.Haddr2     <= '0;
      bus.Hwdata1    <= '0;
      bus.Hwdata2    <= '0;
      bus.Hwritereg  <= 1'b0;
      bus.Hwritereg1 <= 1'b0;
    end else if (bus.Hreadyin) begin
      bus.Haddr1     <= bus.Haddr;
      bus.Haddr2     <= bus.Haddr1;
      bus.Hwdata1    <= bus.Hwdata;
      bus.Hwdata2    <= bus.Hwdata1;
      bus.Hwritereg  <= bus.Hwrite;
      bus.Hwritereg1 <= bus.Hwritereg;
    end
  end

  // Response state register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ERR1 always moves on to ERR2; every other state decodes the incoming transfer.
  always_comb begin
    state_nxt = ST_IDLE;
    unique case (state)
      ST_ERR1: state_nxt = ST_ERR2;
      ST_IDLE,
      ST_OKAY,
      ST_ERR2: begin
        if (xfer_req && !in_map) begin
          state_nxt = ST_ERR1;
        end else if (valid_c) begin
          state_nxt = ST_OKAY;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response outputs: wait states come from the controller except during the error pair.
  always_comb begin
    bus.Hreadyout = bus.Pready_ctl;
    bus.Hresp     = LP_RESP_OKAY;
    unique case (state)
      ST_ERR1: begin
        bus.Hreadyout = 1'b0;
        bus.Hresp     = LP_RESP_ERROR;
      end
      ST_ERR2: begin
        bus.Hreadyout = 1'b1;
        bus.Hresp     = LP_RESP_ERROR;
      end
      default: begin
        bus.Hreadyout = bus.Pready_ctl;
        bus.Hresp     = LP_RESP_OKAY;
      end
    endcase
  end

endmodule
